// File: rtl/myproject_mac_pkg.sv
// Shared types and helpers for the pipelined signed MAC: default widths,
// sign extension, floor shift and saturating narrow on a 64-bit working type.
package myproject_mac_pkg;

  localparam int DFLT_DIN0_WIDTH = 16;
  localparam int DFLT_DIN1_WIDTH = 12;
  localparam int DFLT_ACC_WIDTH  = 32;
  localparam int DFLT_DOUT_WIDTH = 16;
  localparam int PROD_WIDTH      = DFLT_DIN0_WIDTH + DFLT_DIN1_WIDTH;
  localparam int SHIFTED_WIDTH   = 22;

  // All arithmetic helpers work on this width; ACC_WIDTH must not exceed it.
  localparam int WIDE_W = 64;
  typedef logic signed [WIDE_W-1:0] wide_t;

  typedef struct packed {
    logic  ovf;
    wide_t val;
  } sat_t;

  function automatic wide_t sext_to_acc(input wide_t raw, input int w);
    return (raw <<< (WIDE_W - w)) >>> (WIDE_W - w);
  endfunction

  function automatic wide_t shift_floor(input wide_t v, input int sh);
    return v >>> sh;
  endfunction

  function automatic wide_t sat_max(input int dw);
    return (wide_t'(1) <<< (dw - 1)) - wide_t'(1);
  endfunction

  function automatic wide_t sat_min(input int dw);
    return -(wide_t'(1) <<< (dw - 1));
  endfunction

  function automatic sat_t sat_narrow(input wide_t v, input int dw);
    sat_t r;
    r.val = v;
    r.ovf = 1'b0;
    if (v > sat_max(dw)) begin
      r.val = sat_max(dw);
      r.ovf = 1'b1;
    end else if (v < sat_min(dw)) begin
      r.val = sat_min(dw);
      r.ovf = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/myproject_mac_mul_pipe.sv
// Signed full-width multiplier followed by NUM_STAGE registers carrying the
// product with its valid/first/last sideband; ce=0 freezes every stage.
module myproject_mac_mul_pipe
  import myproject_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = DFLT_DIN0_WIDTH,
  parameter int DIN1_WIDTH = DFLT_DIN1_WIDTH,
  parameter int NUM_STAGE  = 2,
  parameter int P_WIDTH    = PROD_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         first,
  input  logic                         last,
  output logic                         out_valid,
  output logic                         out_first,
  output logic                         out_last,
  output logic signed [P_WIDTH-1:0]    out_prod
);

  logic signed [P_WIDTH-1:0] a_ext, b_ext;
  logic signed [P_WIDTH-1:0] prod_q [NUM_STAGE];
  logic signed [P_WIDTH-1:0] prod_d [NUM_STAGE];
  logic [NUM_STAGE-1:0] vld_q, vld_d, fst_q, fst_d, lst_q, lst_d;

  assign a_ext = {{DIN1_WIDTH{din0[DIN0_WIDTH-1]}}, din0};
  assign b_ext = {{DIN0_WIDTH{din1[DIN1_WIDTH-1]}}, din1};

  always_comb begin
    prod_d[0] = a_ext * b_ext;
    vld_d[0]  = in_valid;
    fst_d[0]  = first;
    lst_d[0]  = last;
    for (int i = 1; i < NUM_STAGE; i++) begin
      prod_d[i] = prod_q[i-1];
      vld_d[i]  = vld_q[i-1];
      fst_d[i]  = fst_q[i-1];
      lst_d[i]  = lst_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STAGE; i++) prod_q[i] <= '0;
      vld_q <= '0;
      fst_q <= '0;
      lst_q <= '0;
    end else if (ce) begin
      prod_q <= prod_d;
      vld_q  <= vld_d;
      fst_q  <= fst_d;
      lst_q  <= lst_d;
    end
  end

  assign out_prod  = prod_q[NUM_STAGE-1];
  assign out_valid = vld_q[NUM_STAGE-1];
  assign out_first = fst_q[NUM_STAGE-1];
  assign out_last  = lst_q[NUM_STAGE-1];

endmodule

// File: rtl/myproject_mac_pipe.sv
// Pipelined signed MAC with first/last framed accumulation and floor-shifted
// output. Define MYPROJECT_MAC_SAT_EN to saturate dout and drive ovf.
module myproject_mac_pipe
  import myproject_mac_pkg::*;
#(
  parameter int DIN0_WIDTH = DFLT_DIN0_WIDTH,
  parameter int DIN1_WIDTH = DFLT_DIN1_WIDTH,
  parameter int ACC_WIDTH  = DFLT_ACC_WIDTH,
  parameter int DOUT_WIDTH = DFLT_DOUT_WIDTH,
  parameter int NUM_STAGE  = 2,
  parameter int FRAC_SHIFT = DFLT_ACC_WIDTH - SHIFTED_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         first,
  input  logic                         last,
  output logic                         out_valid,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         ovf
);

  localparam int PROD_W = DIN0_WIDTH + DIN1_WIDTH;

  logic                     t_valid, t_first, t_last;
  logic signed [PROD_W-1:0] t_prod;

  myproject_mac_mul_pipe #(
    .DIN0_WIDTH(DIN0_WIDTH),
    .DIN1_WIDTH(DIN1_WIDTH),
    .NUM_STAGE (NUM_STAGE),
    .P_WIDTH   (PROD_W)
  ) u_mul_pipe (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .in_valid (in_valid),
    .din0     (din0),
    .din1     (din1),
    .first    (first),
    .last     (last),
    .out_valid(t_valid),
    .out_first(t_first),
    .out_last (t_last),
    .out_prod (t_prod)
  );

  logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, acc_next;
  logic signed [DOUT_WIDTH-1:0] dout_q, dout_d;
  logic                         out_valid_q, out_valid_d;
  wide_t                        prod_ext, acc_ext, sum, shifted;
`ifdef MYPROJECT_MAC_SAT_EN
  logic ovf_q, ovf_d;
  sat_t sat_r;
`endif

  always_comb begin
    acc_d       = acc_q;
    dout_d      = dout_q;
    out_valid_d = 1'b0;
    prod_ext    = sext_to_acc(wide_t'($unsigned(t_prod)), PROD_W);
    acc_ext     = sext_to_acc(wide_t'($unsigned(acc_q)), ACC_WIDTH);
    sum         = t_first ? prod_ext : acc_ext + prod_ext;
    // Truncating to ACC_WIDTH gives the modulo-2^ACC_WIDTH wrap.
    acc_next    = sum[ACC_WIDTH-1:0];
    shifted     = shift_floor(sext_to_acc(wide_t'($unsigned(acc_next)), ACC_WIDTH),
                              FRAC_SHIFT);
`ifdef MYPROJECT_MAC_SAT_EN
    ovf_d = ovf_q;
    sat_r = sat_narrow(shifted, DOUT_WIDTH);
`endif
    if (t_valid) begin
      acc_d = acc_next;
      if (t_last) begin
        out_valid_d = 1'b1;
`ifdef MYPROJECT_MAC_SAT_EN
        dout_d = sat_r.val[DOUT_WIDTH-1:0];
        ovf_d  = sat_r.ovf;
`else
        dout_d = shifted[DOUT_WIDTH-1:0];
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q       <= '0;
      dout_q      <= '0;
      out_valid_q <= 1'b0;
`ifdef MYPROJECT_MAC_SAT_EN
      ovf_q       <= 1'b0;
`endif
    end else if (ce) begin
      acc_q       <= acc_d;
      dout_q      <= dout_d;
      out_valid_q <= out_valid_d;
`ifdef MYPROJECT_MAC_SAT_EN
      ovf_q       <= ovf_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
`ifdef MYPROJECT_MAC_SAT_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
